// File: rtl/template_rom_arbiter.sv
`timescale 1ns/1ps
// Round-robin burst arbiter in front of one single-port synchronous template ROM.
// Grants one burst at a time, streams ROM addresses and tags returned words with owner and last flag.
module template_rom_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_len,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_data,
    output logic                          rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [1:0]                    rd_id,
    output logic                          rd_last,
    output logic                          busy
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   len_q, len_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [1:0]              id_q, id_d;
    logic [1:0]              last_grant_q, last_grant_d;

    logic                    win_found;
    logic [1:0]              win_id;
    logic [NUM_REQ-1:0]      win_oh;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [ADDR_WIDTH-1:0]   win_len;
    logic                    issue;
    logic                    issue_last;

    logic [RD_LATENCY-1:0]       pipe_vld_q;
    logic [RD_LATENCY-1:0]       pipe_last_q;
    logic [RD_LATENCY-1:0][1:0]  pipe_id_q;

    // Round-robin search: first requesting index after the previous winner, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_oh    = '0;
        win_addr  = '0;
        win_len   = '0;
        for (int ofs = 1; ofs <= NUM_REQ; ofs++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!win_found && req_valid[r] &&
                    r == (int'(last_grant_q) + ofs) % NUM_REQ) begin
                    win_found = 1'b1;
                    win_id    = 2'(r);
                    win_oh[r] = 1'b1;
                    win_addr  = req_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
                    win_len   = req_len[r*ADDR_WIDTH +: ADDR_WIDTH];
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        req_ready    = '0;
        issue        = 1'b0;
        issue_last   = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by rst_n so no grant pulse leaks out while reset is held.
                if (win_found && rst_n) begin
                    req_ready    = win_oh;
                    addr_d       = win_addr;
                    len_d        = win_len;
                    id_d         = win_id;
                    cnt_d        = '0;
                    last_grant_d = win_id;
                    state_d      = BURST;
                end
            end
            BURST: begin
                issue      = 1'b1;
                issue_last = (cnt_q == len_q);
                if (issue_last) begin
                    state_d = IDLE;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    addr_d = addr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            id_q         <= '0;
            last_grant_q <= 2'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Return tags track the ROM latency independently of the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
            pipe_id_q   <= '0;
        end else begin
            pipe_vld_q[0]  <= issue;
            pipe_last_q[0] <= issue_last;
            pipe_id_q[0]   <= issue ? id_q : 2'b00;
            for (int s = 1; s < RD_LATENCY; s++) begin
                pipe_vld_q[s]  <= pipe_vld_q[s-1];
                pipe_last_q[s] <= pipe_last_q[s-1];
                pipe_id_q[s]   <= pipe_id_q[s-1];
            end
        end
    end

    assign rom_addr = addr_q;
    assign rd_valid = pipe_vld_q[RD_LATENCY-1];
    assign rd_last  = pipe_last_q[RD_LATENCY-1];
    assign rd_id    = pipe_id_q[RD_LATENCY-1];
    assign rd_data  = rom_data;
    assign busy     = (state_q == BURST) | (|pipe_vld_q);

endmodule

// File: tb/tb_template_rom_arbiter.sv
`timescale 1ns/1ps
// Bench for template_rom_arbiter: a latency-1 and a latency-2 instance share one request bus,
// each with a behavioural ROM that returns addr[7:0].
module tb_template_rom_arbiter;

    localparam int AW   = 11;
    localparam int NCYC = 600;
    localparam int MAXC = 700;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [2*AW-1:0] req_addr;
    logic [2*AW-1:0] req_len;

    logic [1:0]    a_req_ready, b_req_ready;
    logic [AW-1:0] a_rom_addr, b_rom_addr;
    logic [7:0]    a_rom_data, b_rom_data, b_rom_p;
    logic          a_rd_valid, b_rd_valid;
    logic [7:0]    a_rd_data, b_rd_data;
    logic [1:0]    a_rd_id, b_rd_id;
    logic          a_rd_last, b_rd_last;
    logic          a_busy, b_busy;

    int n_checks = 0;
    int n_fail   = 0;

    bit         ex_iss  [MAXC];
    logic [10:0] ex_addr [MAXC];
    bit         ex_v    [2][MAXC];
    logic [7:0] ex_d    [2][MAXC];
    logic [1:0] ex_id   [2][MAXC];
    bit         ex_last [2][MAXC];

    always #5 clk = ~clk;

    template_rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(8), .NUM_REQ(2), .RD_LATENCY(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
        .req_ready(a_req_ready), .rom_addr(a_rom_addr), .rom_data(a_rom_data),
        .rd_valid(a_rd_valid), .rd_data(a_rd_data), .rd_id(a_rd_id), .rd_last(a_rd_last),
        .busy(a_busy));

    template_rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(8), .NUM_REQ(2), .RD_LATENCY(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
        .req_ready(b_req_ready), .rom_addr(b_rom_addr), .rom_data(b_rom_data),
        .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_id(b_rd_id), .rd_last(b_rd_last),
        .busy(b_busy));

    always @(posedge clk) a_rom_data <= a_rom_addr[7:0];
    always @(posedge clk) begin
        b_rom_p    <= b_rom_addr[7:0];
        b_rom_data <= b_rom_p;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [10:0] a, input logic [10:0] l);
        req_addr[i*AW +: AW] = a;
        req_len[i*AW +: AW]  = l;
    endtask

    task automatic wait_idle();
        int n = 0;
        sample();
        while ((a_busy !== 1'b0 || b_busy !== 1'b0) && n < 100) begin
            sample();
            n++;
        end
        n_checks++;
        if (n >= 100) begin
            n_fail++;
            $display("FAIL wait_idle: busy a=%b b=%b after 100 cycles, want 0", a_busy, b_busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        req_addr = '0;
        req_len = '0;
        step();
        step();
        sample();
        n_checks += 12;
        if (a_req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_a_ready: got %b want 00", a_req_ready); end
        if (b_req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_b_ready: got %b want 00", b_req_ready); end
        if (a_rom_addr !== 11'h000) begin n_fail++; $display("FAIL rst_a_addr: got %h want 000", a_rom_addr); end
        if (b_rom_addr !== 11'h000) begin n_fail++; $display("FAIL rst_b_addr: got %h want 000", b_rom_addr); end
        if (a_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_a_vld: got %b want 0", a_rd_valid); end
        if (b_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_b_vld: got %b want 0", b_rd_valid); end
        if (a_rd_id !== 2'b00) begin n_fail++; $display("FAIL rst_a_id: got %h want 0", a_rd_id); end
        if (b_rd_id !== 2'b00) begin n_fail++; $display("FAIL rst_b_id: got %h want 0", b_rd_id); end
        if (a_rd_last !== 1'b0) begin n_fail++; $display("FAIL rst_a_last: got %b want 0", a_rd_last); end
        if (b_rd_last !== 1'b0) begin n_fail++; $display("FAIL rst_b_last: got %b want 0", b_rd_last); end
        if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_a_busy: got %b want 0", a_busy); end
        if (b_busy !== 1'b0) begin n_fail++; $display("FAIL rst_b_busy: got %b want 0", b_busy); end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        wait_idle();
        step();
        set_req(0, 11'h010, 11'd3);
        req_valid = 2'b01;
        sample();
        n_checks++;
        if (a_req_ready !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b want 01", a_req_ready); end
        for (int c = 1; c <= 6; c++) begin
            step();
            req_valid = 2'b00;
            sample();
            n_checks++;
            if (a_req_ready !== 2'b00) begin n_fail++; $display("FAIL single_ready c%0d: got %b want 00", c, a_req_ready); end
            if (c <= 4) begin
                n_checks++;
                if (a_rom_addr !== 11'h010 + 11'(c-1))
                    begin n_fail++; $display("FAIL single_addr c%0d: got %h want %h", c, a_rom_addr, 11'h010 + 11'(c-1)); end
            end
            n_checks++;
            if (a_rd_valid !== (c >= 2 && c <= 5))
                begin n_fail++; $display("FAIL single_vld c%0d: got %b want %b", c, a_rd_valid, (c >= 2 && c <= 5)); end
            if (c >= 2 && c <= 5) begin
                n_checks += 3;
                if (a_rd_data !== 8'h10 + 8'(c-2))
                    begin n_fail++; $display("FAIL single_data c%0d: got %h want %h", c, a_rd_data, 8'h10 + 8'(c-2)); end
                if (a_rd_id !== 2'd0) begin n_fail++; $display("FAIL single_id c%0d: got %0d want 0", c, a_rd_id); end
                if (a_rd_last !== (c == 5))
                    begin n_fail++; $display("FAIL single_last c%0d: got %b want %b", c, a_rd_last, (c == 5)); end
            end
        end
        n_checks++;
        if (a_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", a_busy); end
    endtask

    task automatic test_contention();
        int ng = 0;
        int last_c = 0;
        int prev_w = 1;
        int lens [2];
        logic [1:0] exp_oh;
        lens[0] = 1;
        lens[1] = 2;
        wait_idle();
        step();
        rst_n = 1'b0;
        set_req(0, 11'h100, 11'd1);
        set_req(1, 11'h200, 11'd2);
        req_valid = 2'b11;
        sample();
        n_checks += 2;
        if (a_req_ready !== 2'b00) begin n_fail++; $display("FAIL cont_rst_ready_a: got %b want 00", a_req_ready); end
        if (b_req_ready !== 2'b00) begin n_fail++; $display("FAIL cont_rst_ready_b: got %b want 00", b_req_ready); end
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            sample();
            if (a_req_ready !== 2'b00) begin
                exp_oh = (prev_w == 0) ? 2'b10 : 2'b01;
                n_checks += 2;
                if (a_req_ready !== exp_oh) begin n_fail++; $display("FAIL cont_grant_a #%0d: got %b want %b", ng, a_req_ready, exp_oh); end
                if (b_req_ready !== exp_oh) begin n_fail++; $display("FAIL cont_grant_b #%0d: got %b want %b", ng, b_req_ready, exp_oh); end
                if (ng > 0) begin
                    n_checks++;
                    if (c - last_c != lens[prev_w] + 2)
                        begin n_fail++; $display("FAIL cont_gap #%0d: got %0d want %0d", ng, c - last_c, lens[prev_w] + 2); end
                end
                prev_w = (prev_w + 1) % 2;
                last_c = c;
                ng++;
            end
            step();
        end
        req_valid = 2'b00;
        n_checks++;
        if (ng < 4) begin n_fail++; $display("FAIL cont_count: got %0d grants want 4", ng); end
    endtask

    task automatic test_wrap();
        logic [10:0] exp_a [4];
        exp_a = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
        wait_idle();
        step();
        set_req(1, 11'h7FE, 11'd3);
        req_valid = 2'b10;
        sample();
        n_checks++;
        if (a_req_ready !== 2'b10) begin n_fail++; $display("FAIL wrap_grant: got %b want 10", a_req_ready); end
        for (int c = 1; c <= 5; c++) begin
            step();
            req_valid = 2'b00;
            sample();
            if (c <= 4) begin
                n_checks++;
                if (a_rom_addr !== exp_a[c-1])
                    begin n_fail++; $display("FAIL wrap_addr c%0d: got %h want %h", c, a_rom_addr, exp_a[c-1]); end
            end
            if (c >= 2) begin
                n_checks += 4;
                if (a_rd_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_vld c%0d: got %b want 1", c, a_rd_valid); end
                if (a_rd_data !== exp_a[c-2][7:0])
                    begin n_fail++; $display("FAIL wrap_data c%0d: got %h want %h", c, a_rd_data, exp_a[c-2][7:0]); end
                if (a_rd_id !== 2'd1) begin n_fail++; $display("FAIL wrap_id c%0d: got %0d want 1", c, a_rd_id); end
                if (a_rd_last !== (c == 5))
                    begin n_fail++; $display("FAIL wrap_last c%0d: got %b want %b", c, a_rd_last, (c == 5)); end
            end
        end
    endtask

    task automatic test_min_len();
        int nv = 0;
        wait_idle();
        step();
        set_req(0, 11'h055, 11'd0);
        req_valid = 2'b01;
        sample();
        n_checks++;
        if (a_req_ready !== 2'b01) begin n_fail++; $display("FAIL min_grant: got %b want 01", a_req_ready); end
        for (int c = 1; c <= 5; c++) begin
            step();
            req_valid = 2'b00;
            sample();
            if (a_rd_valid === 1'b1) nv++;
            n_checks++;
            if (a_busy !== (c <= 2)) begin n_fail++; $display("FAIL min_busy c%0d: got %b want %b", c, a_busy, (c <= 2)); end
            if (c == 2) begin
                n_checks += 3;
                if (a_rd_valid !== 1'b1) begin n_fail++; $display("FAIL min_vld: got %b want 1", a_rd_valid); end
                if (a_rd_last !== 1'b1) begin n_fail++; $display("FAIL min_last: got %b want 1", a_rd_last); end
                if (a_rd_data !== 8'h55) begin n_fail++; $display("FAIL min_data: got %h want 55", a_rd_data); end
            end
        end
        n_checks++;
        if (nv != 1) begin n_fail++; $display("FAIL min_count: got %0d words want 1", nv); end
    endtask

    task automatic test_back_to_back();
        // Requester 0 won most recently, so requester 1 is granted first here.
        logic [7:0] exp_d [10];
        logic [1:0] exp_i [10];
        bit         exp_v [10];
        bit         exp_l [10];
        logic [1:0] seen = 2'b00;
        int nw = 0;
        for (int i = 0; i < 10; i++) begin exp_v[i] = 0; exp_d[i] = '0; exp_i[i] = '0; exp_l[i] = 0; end
        exp_v[3] = 1; exp_d[3] = 8'h40; exp_i[3] = 2'd1; exp_l[3] = 0;
        exp_v[4] = 1; exp_d[4] = 8'h41; exp_i[4] = 2'd1; exp_l[4] = 1;
        exp_v[6] = 1; exp_d[6] = 8'h20; exp_i[6] = 2'd0; exp_l[6] = 0;
        exp_v[7] = 1; exp_d[7] = 8'h21; exp_i[7] = 2'd0; exp_l[7] = 1;
        wait_idle();
        step();
        set_req(0, 11'h020, 11'd1);
        set_req(1, 11'h040, 11'd1);
        req_valid = 2'b11;
        sample();
        seen = b_req_ready;
        n_checks++;
        if (b_req_ready !== 2'b10) begin n_fail++; $display("FAIL b2b_grant1: got %b want 10", b_req_ready); end
        for (int c = 1; c <= 9; c++) begin
            step();
            req_valid = req_valid & ~seen;
            sample();
            seen = seen | b_req_ready;
            n_checks++;
            if (b_req_ready !== ((c == 3) ? 2'b01 : 2'b00))
                begin n_fail++; $display("FAIL b2b_ready c%0d: got %b want %b", c, b_req_ready, (c == 3) ? 2'b01 : 2'b00); end
            n_checks++;
            if (b_rd_valid !== exp_v[c]) begin n_fail++; $display("FAIL b2b_vld c%0d: got %b want %b", c, b_rd_valid, exp_v[c]); end
            if (b_rd_valid === 1'b1) nw++;
            if (exp_v[c]) begin
                n_checks += 3;
                if (b_rd_data !== exp_d[c]) begin n_fail++; $display("FAIL b2b_data c%0d: got %h want %h", c, b_rd_data, exp_d[c]); end
                if (b_rd_id !== exp_i[c]) begin n_fail++; $display("FAIL b2b_id c%0d: got %0d want %0d", c, b_rd_id, exp_i[c]); end
                if (b_rd_last !== exp_l[c]) begin n_fail++; $display("FAIL b2b_last c%0d: got %b want %b", c, b_rd_last, exp_l[c]); end
            end
            if (c == 3 || c == 8) begin
                n_checks++;
                if (b_busy !== (c == 3)) begin n_fail++; $display("FAIL b2b_busy c%0d: got %b want %b", c, b_busy, (c == 3)); end
            end
        end
        n_checks++;
        if (nw != 4) begin n_fail++; $display("FAIL b2b_count: got %0d words want 4", nw); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] seen;
        wait_idle();
        step();
        set_req(0, 11'h300, 11'd7);
        req_valid = 2'b01;
        sample();
        n_checks++;
        if (a_req_ready !== 2'b01) begin n_fail++; $display("FAIL rmid_grant: got %b want 01", a_req_ready); end
        for (int c = 1; c <= 3; c++) begin
            step();
            req_valid = 2'b00;
            sample();
        end
        n_checks += 2;
        if (a_rom_addr !== 11'h302) begin n_fail++; $display("FAIL rmid_k2: got %h want 302", a_rom_addr); end
        if (a_rd_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_vld: got %b want 1", a_rd_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks += 6;
        if (a_rom_addr !== 11'h000) begin n_fail++; $display("FAIL rmid_addr: got %h want 000", a_rom_addr); end
        if (a_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_vld: got %b want 0", a_rd_valid); end
        if (a_rd_last !== 1'b0) begin n_fail++; $display("FAIL rmid_last: got %b want 0", a_rd_last); end
        if (a_rd_id !== 2'd0) begin n_fail++; $display("FAIL rmid_id: got %0d want 0", a_rd_id); end
        if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", a_busy); end
        if (b_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy_b: got %b want 0", b_busy); end
        step();
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            sample();
            n_checks++;
            if (a_rd_valid !== 1'b0 || b_rd_valid !== 1'b0)
                begin n_fail++; $display("FAIL rmid_quiet c%0d: got a=%b b=%b want 0", c, a_rd_valid, b_rd_valid); end
            step();
        end
        set_req(0, 11'h011, 11'd1);
        set_req(1, 11'h022, 11'd1);
        req_valid = 2'b11;
        sample();
        n_checks += 2;
        if (a_req_ready !== 2'b01) begin n_fail++; $display("FAIL rmid_first_a: got %b want 01", a_req_ready); end
        if (b_req_ready !== 2'b01) begin n_fail++; $display("FAIL rmid_first_b: got %b want 01", b_req_ready); end
        seen = a_req_ready;
        for (int c = 0; c < 12; c++) begin
            step();
            req_valid = req_valid & ~seen;
            sample();
            seen = seen | a_req_ready;
        end
        req_valid = 2'b00;
    endtask

    task automatic test_random();
        bit          pend [2];
        logic [10:0] paddr [2];
        logic [10:0] plen [2];
        logic [10:0] wa;
        logic [1:0]  exp_rdy;
        int free_c, lastg, w, nw, idx;
        bit eb;
        for (int i = 0; i < MAXC; i++) begin
            ex_iss[i] = 0; ex_addr[i] = '0;
            for (int l = 0; l < 2; l++) begin ex_v[l][i] = 0; ex_d[l][i] = '0; ex_id[l][i] = '0; ex_last[l][i] = 0; end
        end
        pend[0] = 0; pend[1] = 0;
        paddr[0] = '0; paddr[1] = '0; plen[0] = '0; plen[1] = '0;
        wait_idle();
        step();
        req_valid = 2'b00;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        free_c = 0;
        lastg = 1;
        for (int c = 0; c < NCYC + 30; c++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && c < NCYC && $urandom_range(0, 9) < 4) begin
                    pend[i] = 1;
                    paddr[i] = ($urandom_range(0, 3) == 0) ? 11'(2047 - $urandom_range(0, 3))
                                                           : 11'($urandom_range(0, 2047));
                    plen[i] = 11'($urandom_range(0, 5));
                    set_req(i, paddr[i], plen[i]);
                end
                req_valid[i] = pend[i];
            end
            sample();
            exp_rdy = 2'b00;
            w = -1;
            if (c >= free_c)
                for (int j = 1; j <= 2; j++) begin
                    nw = (lastg + j) % 2;
                    if (w < 0 && pend[nw]) w = nw;
                end
            if (w >= 0) begin
                exp_rdy[w] = 1'b1;
                lastg = w;
                free_c = c + int'(plen[w]) + 2;
                pend[w] = 0;
                for (int k = 0; k <= int'(plen[w]); k++) begin
                    wa = paddr[w] + 11'(k);
                    if (c + 1 + k < MAXC) begin ex_iss[c+1+k] = 1; ex_addr[c+1+k] = wa; end
                    for (int l = 0; l < 2; l++) begin
                        idx = c + 2 + k + l;
                        if (idx < MAXC) begin
                            ex_v[l][idx] = 1; ex_d[l][idx] = wa[7:0];
                            ex_id[l][idx] = 2'(w); ex_last[l][idx] = (k == int'(plen[w]));
                        end
                    end
                end
            end
            n_checks += 2;
            if (a_req_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready_a c%0d: got %b want %b", c, a_req_ready, exp_rdy); end
            if (b_req_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready_b c%0d: got %b want %b", c, b_req_ready, exp_rdy); end
            if (ex_iss[c]) begin
                n_checks += 2;
                if (a_rom_addr !== ex_addr[c]) begin n_fail++; $display("FAIL rnd_addr_a c%0d: got %h want %h", c, a_rom_addr, ex_addr[c]); end
                if (b_rom_addr !== ex_addr[c]) begin n_fail++; $display("FAIL rnd_addr_b c%0d: got %h want %h", c, b_rom_addr, ex_addr[c]); end
            end
            for (int l = 0; l < 2; l++) begin
                eb = ex_iss[c];
                for (int j = 1; j <= l + 1; j++) if (c - j >= 0 && ex_iss[c-j]) eb = 1;
                n_checks += 2;
                if ((l == 0 ? a_busy : b_busy) !== eb)
                    begin n_fail++; $display("FAIL rnd_busy L%0d c%0d: got %b want %b", l + 1, c, (l == 0 ? a_busy : b_busy), eb); end
                if ((l == 0 ? a_rd_valid : b_rd_valid) !== ex_v[l][c])
                    begin n_fail++; $display("FAIL rnd_vld L%0d c%0d: got %b want %b", l + 1, c, (l == 0 ? a_rd_valid : b_rd_valid), ex_v[l][c]); end
                if (ex_v[l][c]) begin
                    n_checks += 3;
                    if ((l == 0 ? a_rd_data : b_rd_data) !== ex_d[l][c])
                        begin n_fail++; $display("FAIL rnd_data L%0d c%0d: got %h want %h", l + 1, c, (l == 0 ? a_rd_data : b_rd_data), ex_d[l][c]); end
                    if ((l == 0 ? a_rd_id : b_rd_id) !== ex_id[l][c])
                        begin n_fail++; $display("FAIL rnd_id L%0d c%0d: got %0d want %0d", l + 1, c, (l == 0 ? a_rd_id : b_rd_id), ex_id[l][c]); end
                    if ((l == 0 ? a_rd_last : b_rd_last) !== ex_last[l][c])
                        begin n_fail++; $display("FAIL rnd_last L%0d c%0d: got %b want %b", l + 1, c, (l == 0 ? a_rd_last : b_rd_last), ex_last[l][c]); end
                end
            end
        end
        req_valid = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_min_len();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/template_rom_arbiter.md
# template_rom_arbiter

Shares one synchronous fruit-template ROM (single read port, fixed read latency) between several template-matching requesters. Each requester asks for a burst of consecutive ROM words. The block grants bursts round-robin, drives the ROM address one word per cycle, and returns the read data tagged with requester ID and a last-word flag. It sits between the recognition pipeline's matcher engines and the template ROM instance.

## Interface
- ADDR_WIDTH, 11, ROM address width; also the width of the burst length field
- DATA_WIDTH, 8, ROM word width
- NUM_REQ, 2, number of requesters (2..4)
- RD_LATENCY, 1, ROM clock-to-data latency in cycles (1 or 2)

- clk  in  1  system clock; the ROM shares this clock
- rst_n  in  1  asynchronous reset, active low
- req_valid  in  NUM_REQ  per-requester burst request
- req_addr  in  NUM_REQ*ADDR_WIDTH  burst start address; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_len  in  NUM_REQ*ADDR_WIDTH  burst length minus 1 (0 = one word)
- req_ready  out  NUM_REQ  one-hot, one-cycle grant pulse
- rom_addr  out  ADDR_WIDTH  ROM address
- rom_data  in  DATA_WIDTH  ROM read data
- rd_valid  out  1  rd_data is valid this cycle
- rd_data  out  DATA_WIDTH  returned word (rom_data passed through)
- rd_id  out  2  requester index owning rd_data
- rd_last  out  1  final word of the burst
- busy  out  1  burst in progress or reads in flight

## Operation
- FSM has two states, IDLE and BURST. Reset state is IDLE.
- IDLE:
  - If any req_valid is high, select a winner by round-robin.
  - Search starts at index last_grant+1 and wraps modulo NUM_REQ.
  - Assert req_ready[winner] combinationally in that same cycle.
  - Latch the winner's addr, len and ID.
  - Update last_grant to the winner.
  - Go to BURST.
- Requester rule: hold req_valid, req_addr and req_len stable until req_ready is seen. Deassert or re-arm the next cycle.
- BURST:
  - rom_addr = start + k for issue index k = 0..len.
  - Address arithmetic is modulo 2^ADDR_WIDTH: 0x7FF+1 wraps to 0x000.
  - Issue counter is ADDR_WIDTH bits. After issuing k == len, return to IDLE.
- req_ready is never asserted in BURST.
- Return pipeline:
  - RD_LATENCY-deep shift register of {valid, id, last}, loaded at each issue.
  - rd_valid, rd_id and rd_last come from the pipe output.
  - rd_data = rom_data (unregistered).
- The return pipeline runs independently of the FSM, so a new burst may be granted while reads are still in flight.
- busy = (state == BURST) | any pipeline valid bit.
- Reset values: req_ready 0, rom_addr 0, rd_valid 0, rd_id 0, rd_last 0, busy 0.
  - last_grant = NUM_REQ-1, so requester 0 wins first.
  - rom_addr holds its last value while IDLE.
- Reset mid-burst: the burst is abandoned and the pipeline is cleared. No rd_valid appears for in-flight addresses. Requesters re-request after reset.

## Timing
- Grant in cycle T (IDLE, req_ready pulse).
- rom_addr = start + k in cycle T+1+k.
- Matching rd_valid/rd_data in cycle T+1+k+RD_LATENCY.
- rd_last in cycle T+1+len+RD_LATENCY.
- FSM is IDLE at T+2+len. The earliest next grant is then, and its first address is at T+3+len (one-cycle address bubble between bursts).
- Throughput within a burst is one word per cycle, with no stalls.
- Simultaneous req_valid: exactly one grant. The others wait; their req_valid stays high.
- A single requester re-requesting continuously is granted every burst when no one else requests.

## Test plan
- Single burst, RD_LATENCY=1, bench ROM returns addr[7:0]:
  - Stimulus: req0 addr 0x010, len 3.
  - Required: req_ready[0] at T; rom_addr 0x010..0x013 at T+1..T+4; rd_data 0x10..0x13 at T+2..T+5 with rd_id 0; rd_last only at T+5.
- Contention:
  - Stimulus: req0 and req1 held high from reset.
  - Required: grants alternate 0,1,0,1. The first grant goes to req0.
- Wrap-around:
  - Stimulus: req1 addr 0x7FE, len 3.
  - Required: rom_addr sequence 0x7FE, 0x7FF, 0x000, 0x001; rd_last on the 4th word; rd_id 1.
- Minimum length:
  - Stimulus: len 0.
  - Required: exactly one rd_valid, with rd_last=1 in the same cycle. busy falls one cycle after rd_valid.
- Back-to-back overlap, RD_LATENCY=2:
  - Stimulus: two len-1 bursts.
  - Required: second grant at T+3, so the first burst's last data (T+4) and the second grant overlap. All 4 words are returned in order with correct rd_id; no word is lost or duplicated.
- Reset mid-burst:
  - Stimulus: rst_n low at issue k=2 of a len-7 burst.
  - Required: all outputs reset immediately; zero rd_valid after release until a new grant; the first post-reset grant goes to requester 0.
